mult_div_unit: RTL and testbench

Iterative 8-bit multiply/divide unit feeding the CPU's HI/LO path.
- The control unit issues mult/multu/div/divu as a one-cycle start pulse with both register operands.
- The unit iterates one bit per clock and writes the 2W-bit result into internal HI/LO registers.
- mfhi/mflo read HI/LO directly. The CPU stalls its PC while busy=1.

---
 rtl/mult_div_unit.sv | 118 +++++++++++
 tb/tb_mult_div_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative WIDTH-bit signed/unsigned multiply/divide writing HI/LO
//   clk, reset         : rising-edge clock, synchronous active-high reset
//   start, op          : one-cycle request; op 00=mult 01=multu 10=div 11=divu
//   operand_a/b        : multiplicand/dividend and multiplier/divisor
//   busy, done         : operation in flight; one-cycle pulse when hi/lo are valid
//   hi, lo             : product halves, or remainder/quotient
//   div_by_zero        : sticky until the next accepted start
module mult_div_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q;
    logic               div_q, sa_q, sb_q, busy_q, done_q, dbz_q;
    logic [WIDTH-1:0]   a_raw_q, rem_q, hi_q, lo_q;
    logic [WIDTH:0]     mag_a_q, mag_b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;

    logic               sa_d, sb_d, div_ge;
    logic [WIDTH:0]     mag_a_d, mag_b_d, mul_sum, div_sh;
    logic [WIDTH-1:0]   rem_d, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] acc_init_d, acc_d, prod_fix;

    always_comb begin
        sa_d       = ~op[0] & operand_a[WIDTH-1];
        sb_d       = ~op[0] & operand_b[WIDTH-1];
        // Magnitudes are one bit wider so the most-negative value converts exactly
        mag_a_d    = sa_d ? -{1'b1, operand_a} : {1'b0, operand_a};
        mag_b_d    = sb_d ? -{1'b1, operand_b} : {1'b0, operand_b};
        // Low half holds the multiplier (mult) or the dividend that becomes the quotient (div)
        acc_init_d = {{WIDTH{1'b0}}, op[1] ? mag_a_d[WIDTH-1:0] : mag_b_d[WIDTH-1:0]};
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + mag_a_q;
        div_sh     = {rem_q, acc_q[WIDTH-1]};
        div_ge     = div_sh >= mag_b_q;
        rem_d      = div_ge ? WIDTH'(div_sh - mag_b_q) : div_sh[WIDTH-1:0];
        acc_d      = div_q ? {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge}
                           : (acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]});
        prod_fix   = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo_fix    = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix    = sa_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        div_q   <= op[1];
                        a_raw_q <= operand_a;
                        sa_q    <= sa_d;
                        sb_q    <= sb_d;
                        mag_a_q <= mag_a_d;
                        mag_b_q <= mag_b_d;
                        acc_q   <= acc_init_d;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (div_q) rem_q <= rem_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    // Divide by zero still runs the full iteration count; result is overridden here
                    if (div_q && mag_b_q == '0) begin
                        hi_q  <= a_raw_q;
                        lo_q  <= '1;
                        dbz_q <= 1'b1;
                    end else if (div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: random and directed checks of mult_div_unit against an arithmetic model
module tb_mult_div_unit;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    int           m_rem = 0;
    logic         m_done = 1'b0;
    logic         m_dbz = 1'b0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [16:0]  p_res = '0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo),
        .div_by_zero(div_by_zero)
    );

    // Returns {div_by_zero, hi, lo} straight from integer arithmetic
    function automatic logic [16:0] ref_model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, p, q, r;
        sa = o[0] ? int'(a) : int'($signed(a));
        sb = o[0] ? int'(b) : int'($signed(b));
        if (!o[1]) begin
            p = sa * sb;
            return {1'b0, p[15:0]};
        end
        if (b == 8'h00) return {1'b1, a, 8'hFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[7:0], q[7:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted start produces its result WIDTH+1 edges later
    always @(posedge clk) begin
        if (reset) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_dbz  <= p_res[16];
                    m_hi   <= p_res[15:8];
                    m_lo   <= p_res[7:0];
                    m_done <= 1'b1;
                end
            end else if (start) begin
                p_res <= ref_model(op, operand_a, operand_b);
                m_dbz <= 1'b0;
                m_rem <= W + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_rem > 0);
            chk("done", done, m_done);
            chk("div_by_zero", div_by_zero, m_dbz);
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic wait_done(output int lat, output int bc);
        lat = -1;
        bc  = 0;
        for (int k = 0; k <= 20; k++) begin
            if (busy) bc++;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", lat >= 0, 1);
    endtask

    // Called at a negedge; returns at the negedge of the done cycle
    task automatic do_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int bc);
        start = 1'b1;
        op = o;
        operand_a = a;
        operand_b = b;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h7F;
            3: return 8'h80;
            4: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        int lat, bc, nd;
        chk("ref_multu", ref_model(2'd1, 8'hFF, 8'hFF), 17'h0FE01);
        chk("ref_mult", ref_model(2'd0, 8'hFD, 8'h05), 17'h0FFF1);
        chk("ref_div", ref_model(2'd2, 8'hF9, 8'h02), 17'h0FFFD);
        chk("ref_div_ovf", ref_model(2'd2, 8'h80, 8'hFF), 17'h00080);
        chk("ref_divu0", ref_model(2'd3, 8'h37, 8'h00), 17'h137FF);

        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_dbz", div_by_zero, 0);
        reset = 1'b0;
        @(negedge clk);

        do_op(2'd1, 8'hFF, 8'hFF, lat, bc);
        chk("multu_latency", lat, 9);
        chk("multu_busy_cycles", bc, 9);
        chk("multu_hi", hi, 8'hFE);
        chk("multu_lo", lo, 8'h01);
        do_op(2'd0, 8'hFD, 8'h05, lat, bc);
        chk("b2b_latency", lat, 9);
        chk("mult_neg_hi", hi, 8'hFF);
        chk("mult_neg_lo", lo, 8'hF1);
        do_op(2'd0, 8'h80, 8'h80, lat, bc);
        chk("mult_min_hi", hi, 8'h40);
        chk("mult_min_lo", lo, 8'h00);
        do_op(2'd3, 8'hC8, 8'h07, lat, bc);
        chk("divu_hi", hi, 8'h04);
        chk("divu_lo", lo, 8'h1C);
        do_op(2'd2, 8'hF9, 8'h02, lat, bc);
        chk("div_neg_hi", hi, 8'hFF);
        chk("div_neg_lo", lo, 8'hFD);
        do_op(2'd2, 8'h80, 8'hFF, lat, bc);
        chk("div_ovf_hi", hi, 8'h00);
        chk("div_ovf_lo", lo, 8'h80);
        chk("div_ovf_flag", div_by_zero, 0);
        do_op(2'd3, 8'h37, 8'h00, lat, bc);
        chk("dbz_latency", lat, 9);
        chk("dbz_hi", hi, 8'h37);
        chk("dbz_lo", lo, 8'hFF);
        chk("dbz_flag", div_by_zero, 1);
        @(negedge clk);
        chk("dbz_held", div_by_zero, 1);

        start = 1'b1;
        op = 2'd1;
        operand_a = 8'h02;
        operand_b = 8'h03;
        @(negedge clk);
        start = 1'b0;
        chk("dbz_cleared", div_by_zero, 0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        op = 2'd3;
        operand_a = 8'h11;
        operand_b = 8'h22;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        chk("busy_start_latency", lat, 6);
        chk("busy_start_hi", hi, 8'h00);
        chk("busy_start_lo", lo, 8'h06);
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("no_second_done", nd, 0);

        start = 1'b1;
        op = 2'd1;
        operand_a = 8'hFF;
        operand_b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        reset = 1'b0;
        do_op(2'd1, 8'h02, 8'h03, lat, bc);
        chk("post_rst_hi", hi, 8'h00);
        chk("post_rst_lo", lo, 8'h06);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 399) == 0);
            start = ($urandom_range(0, 2) == 0);
            op = 2'($urandom);
            operand_a = pick();
            operand_b = pick();
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (12) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
